// File: rtl/rtrt_pkg.sv
// Shared ray-tracing types: fixed-point coordinates, sphere records and the
// squared-distance helper used to rank intersection points.
package rtrt_pkg;

  localparam int unsigned COORD_W         = 16;
  localparam int unsigned DIFF_W          = 17;
  localparam int unsigned DIST_W          = 36;
  localparam int unsigned DEFAULT_TIMEOUT = 4096;

  typedef logic signed [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    coord_t z;
  } vec3_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    coord_t z;
    coord_t r;
  } sphere_t;

  typedef logic [DIST_W-1:0] dist_t;

  // Exact square of a 17-bit difference; always non-negative.
  function automatic dist_t sq_diff(input coord_t a, input coord_t b);
    logic signed [DIFF_W-1:0]   d;
    logic signed [2*DIFF_W-1:0] s;
    d = DIFF_W'(a) - DIFF_W'(b);
    s = d * d;
    return DIST_W'($unsigned(s));
  endfunction

  function automatic dist_t dist3(input vec3_t p, input vec3_t o);
    return sq_diff(p.x, o.x) + sq_diff(p.y, o.y) + sq_diff(p.z, o.z);
  endfunction

endpackage

// File: rtl/sphere_table.sv
// Scene storage: one write port, one asynchronous read port, per-entry valid bits.
module sphere_table
  import rtrt_pkg::*;
#(
  parameter int unsigned N_SPHERES = 8,
  parameter int unsigned AW        = $clog2(N_SPHERES)
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          i_we,
  input  logic          i_clr,
  input  logic [AW-1:0] i_waddr,
  input  sphere_t       i_wdata,
  input  logic [AW-1:0] i_raddr,
  output sphere_t       o_rdata_c,
  output logic          o_rvalid_c
);

  sphere_t              r_mem [N_SPHERES];
  logic [N_SPHERES-1:0] r_valid;

  // Clear lands before the write so a combined clear+write leaves one valid entry.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_valid <= '0;
    end else begin
      if (i_clr) r_valid <= '0;
      if (i_we)  r_valid[i_waddr] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata_c  = r_mem[i_raddr];
  assign o_rvalid_c = r_valid[i_raddr];

endmodule

// File: rtl/ray_scene_dispatcher.sv
// Per-ray scene walker: issues one intersector request per valid sphere and
// reports the nearest hit.
module ray_scene_dispatcher
  import rtrt_pkg::*;
#(
  parameter int unsigned N_SPHERES = 8,
  parameter int unsigned TIMEOUT   = DEFAULT_TIMEOUT,
  parameter int unsigned AW        = $clog2(N_SPHERES)
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          SPH_WE,
  input  logic          SPH_CLR,
  input  logic [AW-1:0] SPH_ADDR,
  input  sphere_t       SPH_DATA,
  input  logic          START,
  input  vec3_t         in_p0,
  input  vec3_t         in_p1,
  input  logic          in_BOUNDED,
  input  logic [3:0]    in_THRESHOLD,
  output logic          BUSY,
  output logic          DONE,
  output logic          HIT,
  output logic [AW-1:0] HIT_ID,
  output vec3_t         HIT_POINT,
  output logic          ERR,
  output logic          ISX_ENABLE,
  output sphere_t       ISX_SPHERE,
  output vec3_t         ISX_P0,
  output vec3_t         ISX_P1,
  output logic          ISX_BOUNDED,
  output logic [3:0]    ISX_THRESHOLD,
  input  logic          ISX_READY,
  input  logic          ISX_COLLIDE,
  input  vec3_t         ISX_PINT0,
  input  vec3_t         ISX_PINT1
);

  localparam int unsigned   WD_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(N_SPHERES - 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_ISSUE, S_WAIT_LO, S_WAIT_HI, S_COMPARE, S_FINISH
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_idx, w_idx_nxt;
  logic [WD_W-1:0] r_wdog, w_wdog_nxt;
  logic            r_best_vld, w_best_vld_nxt;
  logic [AW-1:0]   r_best_id, w_best_id_nxt;
  vec3_t           r_best_pt, w_best_pt_nxt;
  dist_t           r_best_d, w_best_d_nxt;
  logic            r_cand_hit, w_cand_hit_nxt;
  vec3_t           r_cand_pt, w_cand_pt_nxt;
  dist_t           r_cand_d, w_cand_d_nxt;

  logic            w_busy_nxt, w_done_nxt, w_hit_nxt, w_err_nxt, w_en_nxt;
  logic [AW-1:0]   w_hit_id_nxt;
  vec3_t           w_hit_pt_nxt, w_p0_nxt, w_p1_nxt;
  sphere_t         w_sphere_nxt, w_tbl_sph;
  logic            w_bounded_nxt, w_tbl_vld, w_timeout;
  logic [3:0]      w_thr_nxt;
  dist_t           w_d0, w_d1;

  sphere_table #(.N_SPHERES(N_SPHERES), .AW(AW)) u_table (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .i_we       (SPH_WE & ~BUSY),
    .i_clr      (SPH_CLR & ~BUSY),
    .i_waddr    (SPH_ADDR),
    .i_wdata    (SPH_DATA),
    .i_raddr    (r_idx),
    .o_rdata_c  (w_tbl_sph),
    .o_rvalid_c (w_tbl_vld)
  );

  assign w_d0      = dist3(ISX_PINT0, ISX_P0);
  assign w_d1      = dist3(ISX_PINT1, ISX_P0);
  assign w_timeout = (r_wdog == WD_LAST);

  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_wdog_nxt     = r_wdog;
    w_best_vld_nxt = r_best_vld;
    w_best_id_nxt  = r_best_id;
    w_best_pt_nxt  = r_best_pt;
    w_best_d_nxt   = r_best_d;
    w_cand_hit_nxt = r_cand_hit;
    w_cand_pt_nxt  = r_cand_pt;
    w_cand_d_nxt   = r_cand_d;
    w_err_nxt      = ERR;
    w_hit_nxt      = HIT;
    w_hit_id_nxt   = HIT_ID;
    w_hit_pt_nxt   = HIT_POINT;
    w_sphere_nxt   = ISX_SPHERE;
    w_p0_nxt       = ISX_P0;
    w_p1_nxt       = ISX_P1;
    w_bounded_nxt  = ISX_BOUNDED;
    w_thr_nxt      = ISX_THRESHOLD;

    unique case (r_state)
      S_IDLE: begin
        if (START) begin
          w_p0_nxt       = in_p0;
          w_p1_nxt       = in_p1;
          w_bounded_nxt  = in_BOUNDED;
          w_thr_nxt      = in_THRESHOLD;
          w_idx_nxt      = '0;
          w_best_vld_nxt = 1'b0;
          w_state_nxt    = S_SCAN;
        end
      end
      S_SCAN: begin
        if (w_tbl_vld) begin
          w_sphere_nxt = w_tbl_sph;
          w_state_nxt  = S_ISSUE;
        end else if (r_idx == LAST_IDX) begin
          w_state_nxt = S_FINISH;
        end else begin
          w_idx_nxt = r_idx + AW'(1);
        end
      end
      S_ISSUE: begin
        w_wdog_nxt  = '0;
        w_state_nxt = S_WAIT_LO;
      end
      S_WAIT_LO, S_WAIT_HI: begin
        w_wdog_nxt = r_wdog + WD_W'(1);
        // Abandoned requests count as a miss; a stale READY in WAIT_LO is ignored.
        if (w_timeout) begin
          w_err_nxt      = 1'b1;
          w_cand_hit_nxt = 1'b0;
          w_state_nxt    = S_COMPARE;
        end else if (r_state == S_WAIT_LO) begin
          if (!ISX_READY) w_state_nxt = S_WAIT_HI;
        end else if (ISX_READY) begin
          w_cand_hit_nxt = ISX_COLLIDE;
          w_cand_pt_nxt  = (w_d1 < w_d0) ? ISX_PINT1 : ISX_PINT0;
          w_cand_d_nxt   = (w_d1 < w_d0) ? w_d1 : w_d0;
          w_state_nxt    = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (r_cand_hit && (!r_best_vld || (r_cand_d < r_best_d))) begin
          w_best_vld_nxt = 1'b1;
          w_best_id_nxt  = r_idx;
          w_best_pt_nxt  = r_cand_pt;
          w_best_d_nxt   = r_cand_d;
        end
        if (r_idx == LAST_IDX) begin
          w_state_nxt = S_FINISH;
        end else begin
          w_idx_nxt   = r_idx + AW'(1);
          w_state_nxt = S_SCAN;
        end
      end
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (w_state_nxt == S_FINISH);
    w_en_nxt   = (w_state_nxt == S_ISSUE);
    // Result registers load so they are valid alongside the DONE pulse.
    if (w_state_nxt == S_FINISH) begin
      w_hit_nxt    = w_best_vld_nxt;
      w_hit_id_nxt = w_best_vld_nxt ? w_best_id_nxt : '0;
      w_hit_pt_nxt = w_best_vld_nxt ? w_best_pt_nxt : '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_wdog        <= '0;
      r_best_vld    <= 1'b0;
      r_best_id     <= '0;
      r_best_pt     <= '0;
      r_best_d      <= '0;
      r_cand_hit    <= 1'b0;
      r_cand_pt     <= '0;
      r_cand_d      <= '0;
      BUSY          <= 1'b0;
      DONE          <= 1'b0;
      HIT           <= 1'b0;
      HIT_ID        <= '0;
      HIT_POINT     <= '0;
      ERR           <= 1'b0;
      ISX_ENABLE    <= 1'b0;
      ISX_SPHERE    <= '0;
      ISX_P0        <= '0;
      ISX_P1        <= '0;
      ISX_BOUNDED   <= 1'b0;
      ISX_THRESHOLD <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_wdog        <= w_wdog_nxt;
      r_best_vld    <= w_best_vld_nxt;
      r_best_id     <= w_best_id_nxt;
      r_best_pt     <= w_best_pt_nxt;
      r_best_d      <= w_best_d_nxt;
      r_cand_hit    <= w_cand_hit_nxt;
      r_cand_pt     <= w_cand_pt_nxt;
      r_cand_d      <= w_cand_d_nxt;
      BUSY          <= w_busy_nxt;
      DONE          <= w_done_nxt;
      HIT           <= w_hit_nxt;
      HIT_ID        <= w_hit_id_nxt;
      HIT_POINT     <= w_hit_pt_nxt;
      ERR           <= w_err_nxt;
      ISX_ENABLE    <= w_en_nxt;
      ISX_SPHERE    <= w_sphere_nxt;
      ISX_P0        <= w_p0_nxt;
      ISX_P1        <= w_p1_nxt;
      ISX_BOUNDED   <= w_bounded_nxt;
      ISX_THRESHOLD <= w_thr_nxt;
    end
  end

endmodule

// File: tb/tb_ray_scene_dispatcher.sv
// Directed bench for ray_scene_dispatcher with a 20-cycle behavioural intersector
// whose READY stays high from the previous result.
module tb_ray_scene_dispatcher;
  import rtrt_pkg::*;

  localparam int unsigned N      = 8;
  localparam int unsigned AW     = 3;
  localparam int unsigned TO     = 64;
  localparam int          BUDGET = 2000;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          SPH_WE = 1'b0;
  logic          SPH_CLR = 1'b0;
  logic [AW-1:0] SPH_ADDR = '0;
  sphere_t       SPH_DATA = '0;
  logic          START = 1'b0;
  vec3_t         in_p0 = '0;
  vec3_t         in_p1 = '0;
  logic          in_BOUNDED = 1'b0;
  logic [3:0]    in_THRESHOLD = '0;

  logic          BUSY, DONE, HIT, ERR, ISX_ENABLE, ISX_BOUNDED;
  logic [AW-1:0] HIT_ID;
  vec3_t         HIT_POINT, ISX_P0, ISX_P1;
  sphere_t       ISX_SPHERE;
  logic [3:0]    ISX_THRESHOLD;

  logic          ISX_READY = 1'b1;
  logic          ISX_COLLIDE = 1'b0;
  vec3_t         ISX_PINT0 = '0;
  vec3_t         ISX_PINT1 = '0;

  always #5 CLK = ~CLK;

  ray_scene_dispatcher #(.N_SPHERES(N), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .SPH_WE(SPH_WE), .SPH_CLR(SPH_CLR),
    .SPH_ADDR(SPH_ADDR), .SPH_DATA(SPH_DATA), .START(START),
    .in_p0(in_p0), .in_p1(in_p1), .in_BOUNDED(in_BOUNDED), .in_THRESHOLD(in_THRESHOLD),
    .BUSY(BUSY), .DONE(DONE), .HIT(HIT), .HIT_ID(HIT_ID), .HIT_POINT(HIT_POINT),
    .ERR(ERR), .ISX_ENABLE(ISX_ENABLE), .ISX_SPHERE(ISX_SPHERE),
    .ISX_P0(ISX_P0), .ISX_P1(ISX_P1), .ISX_BOUNDED(ISX_BOUNDED),
    .ISX_THRESHOLD(ISX_THRESHOLD), .ISX_READY(ISX_READY), .ISX_COLLIDE(ISX_COLLIDE),
    .ISX_PINT0(ISX_PINT0), .ISX_PINT1(ISX_PINT1)
  );

  // Intersector model; the sphere's r field carries the table index it came from.
  logic  m_col  [N];
  logic  m_hang [N];
  vec3_t m_a    [N];
  vec3_t m_b    [N];
  int    m_cnt = 0;
  logic [2:0] m_sel;
  assign m_sel = ISX_SPHERE.r[2:0];

  always @(posedge CLK) begin
    if (ISX_ENABLE) begin
      m_cnt <= 20;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 20) ISX_READY <= 1'b0;
      if (m_cnt == 1 && !m_hang[m_sel]) begin
        ISX_READY   <= 1'b1;
        ISX_COLLIDE <= m_col[m_sel];
        ISX_PINT0   <= m_a[m_sel];
        ISX_PINT1   <= m_b[m_sel];
      end
    end
  end

  typedef struct {
    logic          hit;
    logic [AW-1:0] id;
    vec3_t         pt;
    logic          err;
    int            nen;
    int            lat;
  } exp_t;

  exp_t   exp_q[$];
  int     total = 0;
  int     bad = 0;
  coord_t seen6_x = '0;

  function automatic vec3_t v(input int x, input int y, input int z);
    vec3_t r;
    r.x = coord_t'(x);
    r.y = coord_t'(y);
    r.z = coord_t'(z);
    return r;
  endfunction

  function automatic sphere_t sph(input int x, input int idx);
    sphere_t s;
    s.x = coord_t'(x);
    s.y = coord_t'(0);
    s.z = coord_t'(0);
    s.r = coord_t'(idx);
    return s;
  endfunction

  function automatic exp_t mk(input logic h, input int id, input vec3_t pt,
                              input logic e, input int nen, input int lat);
    exp_t x;
    x.hit = h; x.id = AW'(id); x.pt = pt; x.err = e; x.nen = nen; x.lat = lat;
    return x;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wr(input int addr, input sphere_t d, input logic clr);
    @(negedge CLK);
    SPH_WE = 1'b1; SPH_CLR = clr; SPH_ADDR = AW'(addr); SPH_DATA = d;
    @(negedge CLK);
    SPH_WE = 1'b0; SPH_CLR = 1'b0;
  endtask

  task automatic clr_tbl();
    @(negedge CLK); SPH_CLR = 1'b1;
    @(negedge CLK); SPH_CLR = 1'b0;
  endtask

  // One ray: push expectation at START, pop and compare at DONE.
  task automatic run_ray(input string tag, input vec3_t a, input vec3_t b, input exp_t e,
                         input int inj, input logic sw, input int sw_addr, input sphere_t sw_d);
    int   c;
    int   nen;
    logic got;
    exp_t x;
    @(negedge CLK);
    chk({tag, "_idle"}, 64'(BUSY), 64'(0));
    START = 1'b1; in_p0 = a; in_p1 = b;
    in_BOUNDED = ~in_BOUNDED; in_THRESHOLD = in_THRESHOLD + 4'd1;
    if (sw) begin SPH_WE = 1'b1; SPH_ADDR = AW'(sw_addr); SPH_DATA = sw_d; end
    exp_q.push_back(e);
    @(negedge CLK);
    START = 1'b0; SPH_WE = 1'b0;
    c = 1; nen = 0; got = 1'b0;
    chk({tag, "_busy"}, 64'(BUSY), 64'(1));
    chk({tag, "_bnd"}, 64'(ISX_BOUNDED), 64'(in_BOUNDED));
    while (!got && c < BUDGET) begin
      if (ISX_ENABLE) begin
        nen++;
        if (m_sel == 3'd6) seen6_x = ISX_SPHERE.x;
      end
      if (DONE) begin
        got = 1'b1;
      end else begin
        if (c == inj) begin
          START = 1'b1; SPH_WE = 1'b1; SPH_ADDR = AW'(6); SPH_DATA = sph(222, 6);
          in_p0 = v(1, 1, 1);
        end
        @(negedge CLK);
        c++;
        if (c == inj + 1) begin START = 1'b0; SPH_WE = 1'b0; end
      end
    end
    x = exp_q.pop_front();
    chk({tag, "_done"}, 64'(got), 64'(1));
    chk({tag, "_hit"}, 64'(HIT), 64'(x.hit));
    chk({tag, "_id"}, 64'(HIT_ID), 64'(x.id));
    chk({tag, "_pt"}, 64'(HIT_POINT), 64'(x.pt));
    chk({tag, "_err"}, 64'(ERR), 64'(x.err));
    chk({tag, "_nen"}, 64'(nen), 64'(x.nen));
    chk({tag, "_p0"}, 64'(ISX_P0), 64'(a));
    if (x.lat > 0) chk({tag, "_lat"}, 64'(c), 64'(x.lat));
  endtask

  initial begin
    for (int i = 0; i < int'(N); i++) begin
      m_col[i] = 1'b0; m_hang[i] = 1'b0; m_a[i] = '0; m_b[i] = '0;
    end
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    chk("rst_busy", 64'(BUSY), 64'(0));
    chk("rst_done", 64'(DONE), 64'(0));
    chk("rst_hit", 64'(HIT), 64'(0));
    chk("rst_err", 64'(ERR), 64'(0));
    chk("rst_pt", 64'(HIT_POINT), 64'(0));

    // Empty table.
    run_ray("empty", v(0, 0, 0), v(100, 0, 0), mk(0, 0, v(0, 0, 0), 0, 0, 9), 0, 0, 0, '0);

    // Nearest hit wins; entry 7 reports close points but no collision.
    m_col[2] = 1; m_a[2] = v(40, 0, 0); m_b[2] = v(60, 0, 0);
    m_col[5] = 1; m_a[5] = v(80, 0, 0); m_b[5] = v(20, 0, 0);
    m_col[7] = 0; m_a[7] = v(1, 0, 0);  m_b[7] = v(1, 0, 0);
    wr(2, sph(10, 2), 0); wr(5, sph(20, 5), 0); wr(7, sph(30, 7), 0);
    run_ray("near", v(0, 0, 0), v(100, 0, 0), mk(1, 5, v(20, 0, 0), 0, 3, 0), 0, 0, 0, '0);

    // Ties: PINT0 over PINT1, lower index over higher; clear+write in one cycle.
    m_col[1] = 1; m_a[1] = v(30, 0, 0); m_b[1] = v(0, 0, 30);
    m_col[3] = 1; m_a[3] = v(0, 30, 0); m_b[3] = v(30, 0, 0);
    wr(1, sph(0, 1), 1); wr(3, sph(0, 3), 0);
    run_ray("tie", v(0, 0, 0), v(100, 0, 0), mk(1, 1, v(30, 0, 0), 0, 2, 0), 0, 0, 0, '0);

    // Timeout on entry 0, entry 4 still wins; ERR then sticks.
    m_hang[0] = 1;
    m_col[4] = 1; m_a[4] = v(-10, 5, 0); m_b[4] = v(-10, 5, 0);
    clr_tbl(); wr(0, sph(0, 0), 0); wr(4, sph(0, 4), 0);
    run_ray("tmo", v(0, 0, 0), v(100, 0, 0), mk(1, 4, v(-10, 5, 0), 1, 2, 0), 0, 0, 0, '0);
    clr_tbl();
    run_ray("sticky", v(0, 0, 0), v(100, 0, 0), mk(1, 2, v(40, 0, 0), 1, 1, 0), 0, 1, 2, sph(0, 2));

    // Requests while busy are dropped; back-to-back START after DONE is taken.
    m_col[6] = 1; m_a[6] = v(7, 7, 7); m_b[6] = v(7, 7, 7);
    clr_tbl(); wr(6, sph(111, 6), 0);
    run_ray("busy1", v(0, 0, 0), v(100, 0, 0), mk(1, 6, v(7, 7, 7), 1, 1, 0), 5, 0, 0, '0);
    chk("busy1_sph", 64'(seen6_x), 64'(coord_t'(111)));
    run_ray("busy2", v(0, 0, 0), v(100, 0, 0), mk(1, 6, v(7, 7, 7), 1, 1, 0), 0, 0, 0, '0);
    chk("busy2_sph", 64'(seen6_x), 64'(coord_t'(111)));

    // Reset while waiting for the intersector result.
    clr_tbl(); wr(3, sph(5, 3), 0);
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
    for (int i = 0; i < 50 && !ISX_ENABLE; i++) @(negedge CLK);
    chk("mid_en_seen", 64'(ISX_ENABLE), 64'(1));
    repeat (6) @(negedge CLK);
    chk("mid_wait_busy", 64'(BUSY), 64'(1));
    RESET_N = 1'b0;
    @(negedge CLK);
    chk("mid_busy", 64'(BUSY), 64'(0));
    chk("mid_done", 64'(DONE), 64'(0));
    chk("mid_hit", 64'(HIT), 64'(0));
    chk("mid_err", 64'(ERR), 64'(0));
    chk("mid_en", 64'(ISX_ENABLE), 64'(0));
    RESET_N = 1'b1;
    run_ray("postrst", v(0, 0, 0), v(100, 0, 0), mk(0, 0, v(0, 0, 0), 0, 0, 9), 0, 0, 0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
